// File: rtl/da_dct_row_sched.sv
// da_dct_row_sched: row scheduler for one shared 4-input DA DCT unit (8 serial coefficients per row)
// Optional DA_ZERO_SKIP_EN: all-zero operand vectors bypass the DA unit and yield a zero coefficient.
module da_dct_row_sched #(
  parameter int DW = 9,
  parameter int DA_LAT = 6
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          row_valid,
  output logic          row_ready,
  input  logic [8*DW-1:0] row_data,
  output logic          da_start,
  output logic [2:0]    da_sel,
  output logic [11:0]   da_x0,
  output logic [11:0]   da_x1,
  output logic [11:0]   da_x2,
  output logic [11:0]   da_x3,
  input  logic [11:0]   da_data_i,
  output logic          coef_valid,
  output logic [11:0]   coef_data,
  output logic [2:0]    coef_idx,
  output logic          row_done
);
  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;
  state_t state, state_nxt;
  logic [3:0] cnt;
  logic [11:0] s [4];
  logic [11:0] d [4];
  logic [11:0] bs [4];
  logic [11:0] bd [4];
  logic [11:0] nx [4];
  logic accept, capture, skip, advance, last;
`ifdef DA_ZERO_SKIP_EN
  assign skip = state == START && ~|{da_x0, da_x1, da_x2, da_x3};
`else
  assign skip = 1'b0;
`endif
  always_comb begin
    row_ready = state == IDLE;
    accept = row_ready && row_valid;
    capture = state == WAIT && cnt == 4'(DA_LAT);
    advance = capture || skip;
    last = da_sel == 3'd7;
    da_start = state == START && !skip;
    state_nxt = accept ? START : advance ? (last ? IDLE : START) : state == START ? WAIT : state;
    for (int i = 0; i < 4; i++) begin
      bs[i] = 12'($signed(row_data[i*DW +: DW])) + 12'($signed(row_data[(7-i)*DW +: DW]));
      bd[i] = 12'($signed(row_data[i*DW +: DW])) - 12'($signed(row_data[(7-i)*DW +: DW]));
      nx[i] = accept ? bs[i] : last ? 12'd0 : da_sel[0] ? s[i] : d[i];
    end
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      cnt <= '0;
      s <= '{default: '0};
      d <= '{default: '0};
      da_sel <= '0;
      da_x0 <= '0;
      da_x1 <= '0;
      da_x2 <= '0;
      da_x3 <= '0;
      coef_valid <= 1'b0;
      coef_data <= '0;
      coef_idx <= '0;
      row_done <= 1'b0;
    end else begin
      cnt <= state == WAIT ? cnt + 4'd1 : 4'd1;
      coef_valid <= advance;
      row_done <= advance && last;
      if (advance) begin
        coef_data <= skip ? 12'd0 : da_data_i;
        coef_idx <= da_sel;
      end
      if (accept) begin
        s <= bs;
        d <= bd;
      end
      if (accept || advance) begin
        da_sel <= accept || last ? 3'd0 : da_sel + 3'd1;
        da_x0 <= nx[0];
        da_x1 <= nx[1];
        da_x2 <= nx[2];
        da_x3 <= nx[3];
      end
    end
endmodule

// File: tb/tb_da_dct_row_sched.sv
// tb_da_dct_row_sched: scoreboard bench with a DA-unit model and a row-level reference model
module tb_da_dct_row_sched;
  localparam int DW = 9;
  localparam int DA_LAT = 6;
  logic sys_clk = 1'b0;
  logic sys_rst_n;
  logic row_valid, row_ready;
  logic [8*DW-1:0] row_data;
  logic da_start;
  logic [2:0] da_sel;
  logic [11:0] da_x0, da_x1, da_x2, da_x3, da_data_i;
  logic coef_valid, row_done;
  logic [11:0] coef_data;
  logic [2:0] coef_idx;
  da_dct_row_sched #(.DW(DW), .DA_LAT(DA_LAT)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .row_valid(row_valid), .row_ready(row_ready),
    .row_data(row_data), .da_start(da_start), .da_sel(da_sel), .da_x0(da_x0), .da_x1(da_x1),
    .da_x2(da_x2), .da_x3(da_x3), .da_data_i(da_data_i), .coef_valid(coef_valid),
    .coef_data(coef_data), .coef_idx(coef_idx), .row_done(row_done)
  );
  always #5 sys_clk = ~sys_clk;
  typedef struct {int idx; logic [11:0] data; bit done; int cyc;} coef_t;
  typedef struct {int sel; logic [47:0] x;} op_t;
  coef_t sbq[$];
  op_t opq[$];
  int n_vec = 0, n_err = 0, cyc = 0, rst_epoch = 0, n_coef = 0;
  localparam logic [127:0] RST_OUTS = 128'({1'b1, 69'b0});
  always @(posedge sys_clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [127:0] outs();
    return 128'({row_ready, da_start, da_sel, da_x3, da_x2, da_x1, da_x0, coef_valid, coef_data, coef_idx, row_done});
  endfunction
  function automatic logic [11:0] da_f(input int k, input int v[4]);
    return 12'(100 + k + v[0] + 3*v[1] + 5*v[2] + 7*v[3]);
  endfunction
  function automatic int rnd();
    return int'($urandom_range((1 << DW) - 1, 0)) - (1 << (DW - 1));
  endfunction
  // DA unit: result valid only on the capture edge, random garbage otherwise
  initial begin
    int v[4], ep;
    logic [47:0] held;
    logic [2:0] sel;
    logic [11:0] res;
    bit ok;
    op_t e;
    da_data_i = '0;
    forever begin
      @(negedge sys_clk);
      if (sys_rst_n && da_start) begin
        ep = rst_epoch;
        held = {da_x3, da_x2, da_x1, da_x0};
        sel = da_sel;
        if (opq.size() == 0) chk("da_job_unexpected", 1, 0);
        else begin
          e = opq.pop_front();
          chk("da_sel", 128'(sel), 128'(e.sel));
          chk("da_operands", 128'(held), 128'(e.x));
        end
        v[0] = int'($signed(da_x0));
        v[1] = int'($signed(da_x1));
        v[2] = int'($signed(da_x2));
        v[3] = int'($signed(da_x3));
        res = da_f(int'(sel), v);
        ok = 1'b1;
        for (int j = 0; j < DA_LAT; j++) begin
          @(negedge sys_clk);
          if (rst_epoch != ep) break;
          ok &= {da_x3, da_x2, da_x1, da_x0} == held && da_sel == sel && !da_start;
          da_data_i = j == DA_LAT - 1 ? res : 12'($urandom);
        end
        if (rst_epoch == ep) chk("da_hold_no_restart", 128'(ok), 1);
      end else da_data_i = 12'($urandom);
    end
  end
  initial begin
    coef_t e;
    forever begin
      @(negedge sys_clk);
      if (sys_rst_n && coef_valid) begin
        n_coef++;
        if (sbq.size() == 0) chk("coef_unexpected", 1, 0);
        else begin
          e = sbq.pop_front();
          chk("coef_data", 128'(coef_data), 128'(e.data));
          chk("coef_idx", 128'(coef_idx), 128'(e.idx));
          chk("row_done", 128'(row_done), 128'(e.done));
          chk("coef_cycle", 128'(cyc), 128'(e.cyc));
        end
      end else if (sys_rst_n && row_done) chk("row_done_orphan", 1, 0);
    end
  end
  task automatic issue(input int x[8], output int e0, output int last_cap);
    int s[4], d[4], v[4], t, cap, g;
    logic [11:0] dat;
    for (int i = 0; i < 8; i++) row_data[i*DW +: DW] = DW'(x[i]);
    row_valid = 1'b1;
    g = 0;
    while (!row_ready && g < 200) begin
      @(negedge sys_clk);
      g++;
    end
    chk("accept_timeout", 128'(g < 200), 1);
    e0 = cyc + 1;
    for (int i = 0; i < 4; i++) begin
      s[i] = x[i] + x[7-i];
      d[i] = x[i] - x[7-i];
    end
    t = e0 + 1;
    cap = t;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 4; i++) v[i] = (k % 2) ? d[i] : s[i];
`ifdef DA_ZERO_SKIP_EN
      if (v[0] == 0 && v[1] == 0 && v[2] == 0 && v[3] == 0) begin
        dat = '0;
        cap = t;
        t += 1;
      end else
`endif
      begin
        opq.push_back('{k, {12'(v[3]), 12'(v[2]), 12'(v[1]), 12'(v[0])}});
        dat = da_f(k, v);
        cap = t + DA_LAT;
        t += DA_LAT + 1;
      end
      sbq.push_back('{k, dat, k == 7, cap});
    end
    last_cap = cap;
    @(negedge sys_clk);
  endtask
  task automatic drain();
    int g;
    g = 0;
    while (sbq.size() != 0 && g < 2000) begin
      @(negedge sys_clk);
      g++;
    end
    chk("drain", 128'(sbq.size()), 0);
    repeat (2) @(negedge sys_clk);
    chk("idle_ready", 128'(row_ready), 1);
  endtask
  initial begin
    int x[8], x2[8], e0, lc, e0b, lcb, g, nc;
    sys_rst_n = 1'b0;
    row_valid = 1'b0;
    row_data = '0;
    repeat (2) @(negedge sys_clk);
    chk("reset_outputs", outs(), RST_OUTS);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    chk("post_reset_outputs", outs(), RST_OUTS);
    x = '{10, 20, 30, 40, 40, 30, 20, 10};
    issue(x, e0, lc);
    row_valid = 1'b0;
    drain();
    for (int i = 0; i < 8; i++) begin
      x[i] = rnd();
      x2[i] = rnd();
    end
    issue(x, e0, lc);
    issue(x2, e0b, lcb);
    row_valid = 1'b0;
    chk("b2b_accept_cycle", 128'(e0b), 128'(lc + 1));
    drain();
    x = '{-256, -256, -256, -256, 255, 255, 255, 255};
    issue(x, e0, lc);
    row_valid = 1'b0;
    drain();
    x = '{0, 0, 0, 0, 0, 0, 0, 0};
    issue(x, e0, lc);
    row_valid = 1'b0;
    drain();
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 8; i++) x[i] = rnd();
      issue(x, e0, lc);
      row_valid = 1'b0;
      repeat (4) @(negedge sys_clk);
      if (!row_ready) begin
        row_data = {(8*DW/8+1){8'($urandom)}};
        row_valid = 1'b1;
        @(negedge sys_clk);
        row_valid = 1'b0;
      end
      if (r % 2 == 1) drain();
    end
    drain();
    for (int i = 0; i < 8; i++) x[i] = rnd();
    x[0] = 5;
    x[7] = 3;
    issue(x, e0, lc);
    row_valid = 1'b0;
    g = 0;
    while (!(da_sel == 3'd3 && !da_start && !row_ready) && g < 500) begin
      @(negedge sys_clk);
      g++;
    end
    chk("reach_job3", 128'(g < 500), 1);
    repeat (2) @(negedge sys_clk);
    #2 sys_rst_n = 1'b0;
    rst_epoch++;
    sbq.delete();
    opq.delete();
    #1 chk("async_reset", outs(), RST_OUTS);
    @(negedge sys_clk);
    chk("reset_held", outs(), RST_OUTS);
    sys_rst_n = 1'b1;
    nc = n_coef;
    repeat (20) @(negedge sys_clk);
    chk("no_coef_after_reset", 128'(n_coef), 128'(nc));
    chk("ready_after_reset", 128'(row_ready), 1);
    for (int i = 0; i < 8; i++) x[i] = rnd();
    issue(x, e0, lc);
    row_valid = 1'b0;
    drain();
    chk("op_queue_empty", 128'(opq.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end
endmodule
